// File: rtl/sccb_init_sequencer.sv
// rtl/sccb_init_sequencer.sv - register-table walker driving a byte-level SCCB/I2C master
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   go             start pulse (accepted in IDLE and DONE)
//   busy/done/err  sequence status; err_index holds the table index that timed out
//   rom_addr/rom_data  table read port, data valid one clock after the address
//   m_tx_data, m_start, m_stop, m_i2c_en  requests to the master
//   m_ready, m_tx_done                   status from the master
module sccb_init_sequencer #(
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         ROM_AW      = 8,
    parameter int         TIMEOUT_CYC = 200000,
    parameter int         DELAY_CYC   = 1000000,
    parameter int         GAP_CYC     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROM_AW-1:0] err_index,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        m_tx_data,
    output logic              m_start,
    output logic              m_stop,
    output logic              m_i2c_en,
    input  logic              m_ready,
    input  logic              m_tx_done
);

    localparam int MAX_TD = (TIMEOUT_CYC > DELAY_CYC) ? TIMEOUT_CYC : DELAY_CYC;
    localparam int MAX_C  = (MAX_TD > GAP_CYC) ? MAX_TD : GAP_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0]     TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]     DELAY_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0]     GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [ROM_AW-1:0] LAST_ADDR  = '1;

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, START_REQ, START_WAIT, BYTE_REQ, BYTE_WAIT,
        STOP_REQ, STOP_WAIT, GAP, DELAY, DONE, FAIL
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]     cnt;
    logic [1:0]        byte_cnt, byte_cnt_next;
    logic [15:0]       entry;
    logic              low_seen;
    logic              txd_seen;
    logic [ROM_AW-1:0] rom_addr_next;
    logic [7:0]        tx_byte_next;
    logic              timed_state;
    logic              timeout;
    logic              wait_ok;
    logic              entering;

    // Watchdog applies only to states that depend on the master.
    assign timed_state = (state == START_REQ) || (state == START_WAIT) ||
                         (state == BYTE_REQ)  || (state == BYTE_WAIT)  ||
                         (state == STOP_REQ)  || (state == STOP_WAIT);
    assign timeout  = timed_state && (cnt == TO_LAST);
    // m_ready must be seen low before its return to high counts as completion.
    assign wait_ok  = low_seen && m_ready;
    assign entering = (state_next != state);

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        rom_addr_next = rom_addr;
        m_start       = 1'b0;
        m_stop        = 1'b0;
        m_i2c_en      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next    = FETCH;
                    rom_addr_next = '0;
                end
            end
            FETCH: state_next = DECODE;
            DECODE: begin
                if (rom_data == END_MARK) begin
                    state_next = DONE;
                end else if (rom_data == DELAY_MARK) begin
                    state_next = DELAY;
                end else begin
                    state_next    = START_REQ;
                    byte_cnt_next = 2'd0;
                end
            end
            START_REQ: begin
                if (timeout) begin
                    state_next = FAIL;
                end else if (m_ready) begin
                    m_i2c_en   = 1'b1;
                    m_start    = 1'b1;
                    state_next = START_WAIT;
                end
            end
            START_WAIT: begin
                if (timeout)      state_next = FAIL;
                else if (wait_ok) state_next = BYTE_REQ;
            end
            BYTE_REQ: begin
                if (timeout) begin
                    state_next = FAIL;
                end else if (m_ready) begin
                    m_i2c_en   = 1'b1;
                    state_next = BYTE_WAIT;
                end
            end
            BYTE_WAIT: begin
                // Without a tx_done the byte is not considered sent; the
                // watchdog resolves a master that never reports it.
                if (timeout) begin
                    state_next = FAIL;
                end else if (wait_ok && txd_seen) begin
                    if (byte_cnt == 2'd2) begin
                        state_next = STOP_REQ;
                    end else begin
                        byte_cnt_next = byte_cnt + 2'd1;
                        state_next    = BYTE_REQ;
                    end
                end
            end
            STOP_REQ: begin
                if (timeout) begin
                    state_next = FAIL;
                end else if (m_ready) begin
                    m_i2c_en   = 1'b1;
                    m_stop     = 1'b1;
                    state_next = STOP_WAIT;
                end
            end
            STOP_WAIT: begin
                if (timeout)      state_next = FAIL;
                else if (wait_ok) state_next = GAP;
            end
            GAP, DELAY: begin
                if (cnt == ((state == GAP) ? GAP_LAST : DELAY_LAST)) begin
                    // The last table slot ends the sequence instead of wrapping.
                    if (rom_addr == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        rom_addr_next = rom_addr + 1'b1;
                        state_next    = FETCH;
                    end
                end
            end
            DONE: begin
                if (go) begin
                    state_next    = FETCH;
                    rom_addr_next = '0;
                end
            end
            FAIL:    state_next = FAIL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_byte_next = entry[7:0];
        case (byte_cnt_next)
            2'd0:    tx_byte_next = DEV_ADDR;
            2'd1:    tx_byte_next = entry[15:8];
            default: tx_byte_next = entry[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_cnt  <= 2'd0;
            entry     <= '0;
            low_seen  <= 1'b0;
            txd_seen  <= 1'b0;
            rom_addr  <= '0;
            m_tx_data <= 8'hFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_index <= '0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
            rom_addr <= rom_addr_next;

            if (entering) begin
                cnt      <= '0;
                low_seen <= 1'b0;
                txd_seen <= 1'b0;
            end else begin
                if (cnt != '1) cnt <= cnt + 1'b1;
                if (!m_ready)  low_seen <= 1'b1;
                if (m_tx_done) txd_seen <= 1'b1;
            end

            if (state == DECODE) entry <= rom_data;

            // Load the byte on entry so it is stable for the strobe and the wait.
            if (entering && state_next == BYTE_REQ) m_tx_data <= tx_byte_next;

            if (entering && state_next == FETCH && (state == IDLE || state == DONE)) begin
                busy <= 1'b1;
                done <= 1'b0;
            end
            if (entering && state_next == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (entering && state_next == FAIL) begin
                busy      <= 1'b0;
                err       <= 1'b1;
                err_index <= rom_addr;
            end
        end
    end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb/tb_sccb_init_sequencer.sv - directed self-checking bench for sccb_init_sequencer
module tb_sccb_init_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] err_index, rom_addr;
    logic [15:0]   rom_data = 16'hFFFF;
    logic [7:0]    m_tx_data;
    logic          m_start, m_stop, m_i2c_en;
    logic          m_ready;
    logic          m_tx_done;

    sccb_init_sequencer #(
        .DEV_ADDR(8'h42), .ROM_AW(AW), .TIMEOUT_CYC(50), .DELAY_CYC(100), .GAP_CYC(10)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .err(err),
        .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data),
        .m_tx_data(m_tx_data), .m_start(m_start), .m_stop(m_stop), .m_i2c_en(m_i2c_en),
        .m_ready(m_ready), .m_tx_done(m_tx_done)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural master: each strobe pulls m_ready low for 3 clocks, a byte
    // also pulses m_tx_done once; optionally hangs after byte number hang_after.
    logic [7:0] byte_log [$];
    int         start_cyc_q [$];
    int         start_cnt = 0, stop_cnt = 0, n_strobe = 0, bad_strobe = 0;
    int         hang_after = 0, hang_cyc = 0, n_bytes = 0;
    logic [1:0] mcnt;
    logic       is_byte, hung;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready   <= 1'b1;
            m_tx_done <= 1'b0;
            mcnt      <= 2'd0;
            is_byte   <= 1'b0;
            hung      <= 1'b0;
        end else begin
            m_tx_done <= 1'b0;
            if (m_i2c_en) begin
                n_strobe++;
                if (!m_ready) bad_strobe++;
                if (m_start) begin
                    start_cyc_q.push_back(cyc);
                    start_cnt++;
                    is_byte <= 1'b0;
                end else if (m_stop) begin
                    stop_cnt++;
                    is_byte <= 1'b0;
                end else begin
                    byte_log.push_back(m_tx_data);
                    n_bytes++;
                    is_byte <= 1'b1;
                    if (hang_after != 0 && n_bytes == hang_after) begin
                        hung     <= 1'b1;
                        hang_cyc = cyc;
                    end
                end
                m_ready <= 1'b0;
                mcnt    <= 2'd3;
            end else if (hung) begin
                m_ready <= 1'b0;
            end else if (mcnt != 2'd0) begin
                mcnt <= mcnt - 2'd1;
                if (mcnt == 2'd3 && is_byte) m_tx_done <= 1'b1;
                if (mcnt == 2'd1) m_ready <= 1'b1;
            end
        end
    end

    int n_total = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] lb(input int i);
        return (i < byte_log.size()) ? byte_log[i] : 8'hxx;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_a();
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'h1100;
    endtask

    int go_cyc;
    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        go_cyc = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        for (int i = 0; i < max_cyc && !(done || err); i++) @(negedge clk);
    endtask

    task automatic check_seq_a(input string tag, input int b0, input int s0, input int p0);
        logic [7:0] exp_a [6];
        exp_a = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h00};
        check({tag, "_nbytes"}, byte_log.size() - b0, 6);
        for (int i = 0; i < 6; i++) check($sformatf("%s_byte%0d", tag, i), lb(b0 + i), exp_a[i]);
        check({tag, "_starts"}, start_cnt - s0, 2);
        check({tag, "_stops"}, stop_cnt - p0, 2);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, s0, p0, ns, diff, sawdone;
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_index", err_index, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_tx_data", m_tx_data, 8'hFF);
        check("rst_strobes", {m_start, m_stop, m_i2c_en}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Two-entry table; go while busy must not restart
        load_a();
        b0 = byte_log.size(); s0 = start_cnt; p0 = stop_cnt;
        pulse_go();
        check("a_busy_after_go", busy, 1);
        repeat (38) @(negedge clk);
        pulse_go();
        wait_end(500);
        check_seq_a("a", b0, s0, p0);

        // go in DONE: restart from 0 and replay identically
        b0 = byte_log.size(); s0 = start_cnt; p0 = stop_cnt;
        check("a_addr_before_replay", rom_addr, 2);
        pulse_go();
        check("replay_rom_addr", rom_addr, 0);
        check("replay_done_clr", done, 0);
        wait_end(500);
        check_seq_a("replay", b0, s0, p0);

        // End marker only
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        s0 = start_cnt;
        pulse_go();
        sawdone = 0;
        for (int i = 0; i < 4 && !sawdone; i++) begin
            if (done) sawdone = 1;
            else @(negedge clk);
        end
        check("ff_done_4clk", sawdone, 1);
        check("ff_no_start", start_cnt - s0, 0);

        // Delay entry ahead of a transaction
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'hFFF0;
        rom[1] = 16'h3A04;
        b0 = byte_log.size(); s0 = start_cnt;
        pulse_go();
        wait_end(500);
        diff = (start_cnt > s0) ? start_cyc_q[s0] - go_cyc : 0;
        check("dly_start_late", (diff >= 102 && diff <= 106), 1);
        check("dly_nbytes", byte_log.size() - b0, 3);
        check("dly_b0", lb(b0), 8'h42);
        check("dly_b1", lb(b0 + 1), 8'h3A);
        check("dly_b2", lb(b0 + 2), 8'h04);
        check("dly_done", done, 1);

        // Master hangs after 2nd byte of index 1
        do_reset();
        load_a();
        n_bytes = 0;
        hang_after = 5;
        pulse_go();
        for (int i = 0; i < 500 && !hung; i++) @(negedge clk);
        check("to_hung", hung, 1);
        for (int i = 0; i < 200 && cyc < hang_cyc + 50; i++) @(negedge clk);
        check("to_err_49", err, 0);
        @(negedge clk);
        check("to_err_50", err, 1);
        check("to_err_index", err_index, 1);
        check("to_busy", busy, 0);
        ns = n_strobe;
        repeat (20) @(negedge clk);
        pulse_go();
        repeat (20) @(negedge clk);
        check("to_no_strobe", n_strobe - ns, 0);
        check("to_go_ignored", busy, 0);
        check("to_err_sticky", err, 1);
        check("to_done", done, 0);
        hang_after = 0;

        // Whole table of delays: last slot ends in DONE without wrapping
        do_reset();
        check("rst_clears_err", err, 0);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFF0;
        s0 = start_cnt;
        pulse_go();
        wait_end(3000);
        check("wrap_done", done, 1);
        check("wrap_addr", rom_addr, 15);
        check("wrap_no_start", start_cnt - s0, 0);

        // Reset in BYTE_WAIT takes effect without a clock edge
        do_reset();
        load_a();
        b0 = byte_log.size();
        pulse_go();
        for (int i = 0; i < 100 && byte_log.size() == b0; i++) @(negedge clk);
        check("mid_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_en", m_i2c_en, 0);
        check("mid_busy_rst", busy, 0);
        check("mid_done_rst", done, 0);
        check("mid_err_rst", err, 0);
        check("mid_tx_data", m_tx_data, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        ns = n_strobe;
        repeat (20) @(negedge clk);
        check("mid_idle_nostrobe", n_strobe - ns, 0);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_addr", rom_addr, 0);

        check("no_strobe_when_not_ready", bad_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
